// File: rtl/soml_peak_detect_if.sv
// Sample stream in, peak report out, for soml_peak_detect.
// The driver (master) supplies start/samples/threshold; the detector (slave) returns status and result.
interface soml_peak_detect_if #(
    parameter int N   = 16,
    parameter int WIN = 64,
    parameter int CW  = $clog2(WIN)
);
    logic                 start;
    logic                 in_valid;
    logic signed [N-1:0]  in_r;
    logic signed [N-1:0]  in_i;
    logic [N:0]           thresh;
    logic                 busy;
    logic                 peak_valid;
    logic [CW-1:0]        peak_idx;
    logic [N:0]           peak_mag;
    logic                 peak_found;

    modport master (
        output start, in_valid, in_r, in_i, thresh,
        input  busy, peak_valid, peak_idx, peak_mag, peak_found
    );

    modport slave (
        input  start, in_valid, in_r, in_i, thresh,
        output busy, peak_valid, peak_idx, peak_mag, peak_found
    );
endinterface

// File: rtl/soml_peak_detect.sv
// L1-magnitude peak search over a window of WIN valid complex samples.
// One register stage between acceptance and compare; result strobed for one cycle on return to idle.
module soml_peak_detect #(
    parameter int N   = 16,
    parameter int Q   = 8,
    parameter int WIN = 64
) (
    input  logic               clk,
    input  logic               rst,
    soml_peak_detect_if.slave  bus
);
    localparam int CW = $clog2(WIN);

    if (WIN < 2 || Q > N) begin : g_bad_param
        $error("soml_peak_detect: WIN must be >= 2 and Q <= N");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]       cnt;
    logic [N:0]          thr_q;
    logic signed [N:0]   r_ext, i_ext;
    logic [N:0]          abs_r, abs_i, mag;
    logic [N:0]          s1_mag;
    logic [CW-1:0]       s1_idx;
    logic                s1_vld;
    logic [N:0]          pk_mag;
    logic [CW-1:0]       pk_idx;
    logic                pk_found;
    logic                pk_vld;
    logic                accept, last, upd, go;
    logic [N:0]          max_nx;

    // Sign-extend one bit first so |-2^(N-1)| is representable; the sum then tops out at 2^N.
    assign r_ext = {bus.in_r[N-1], bus.in_r};
    assign i_ext = {bus.in_i[N-1], bus.in_i};
    assign abs_r = r_ext[N] ? (~r_ext + 1'b1) : r_ext;
    assign abs_i = i_ext[N] ? (~i_ext + 1'b1) : i_ext;
    assign mag   = abs_r + abs_i;

    assign go     = (state == IDLE) && bus.start;
    assign accept = (state == RUN) && bus.in_valid;
    assign last   = accept && (cnt == CW'(WIN - 1));
    // Strict compare keeps the earliest index on ties.
    assign upd    = s1_vld && (s1_mag > pk_mag);
    assign max_nx = upd ? s1_mag : pk_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DRAIN;
            DRAIN:                  state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_mag <= '0;
            s1_idx <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_mag <= mag;
                s1_idx <= cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            thr_q    <= '0;
            pk_mag   <= '0;
            pk_idx   <= '0;
            pk_found <= 1'b0;
            pk_vld   <= 1'b0;
        end else begin
            pk_vld <= (state == DONE);
            if (go) begin
                cnt      <= '0;
                thr_q    <= bus.thresh;
                pk_mag   <= '0;
                pk_idx   <= '0;
                pk_found <= 1'b0;
            end else begin
                if (accept) cnt <= cnt + 1'b1;
                if (upd) begin
                    pk_mag <= s1_mag;
                    pk_idx <= s1_idx;
                end
                // DRAIN carries the last sample's compare, so max_nx is the final peak here.
                if (state == DRAIN) pk_found <= (max_nx >= thr_q);
            end
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.peak_valid = pk_vld;
    assign bus.peak_idx   = pk_idx;
    assign bus.peak_mag   = pk_mag;
    assign bus.peak_found = pk_found;
endmodule

// File: tb/tb_soml_peak_detect.sv
// Directed bench for soml_peak_detect: hand-computed peak results, latency, ignored inputs, reset, chaining.
module tb_soml_peak_detect;
    localparam int N   = 16;
    localparam int WIN = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   sr [WIN];
    int   si [WIN];

    soml_peak_detect_if #(.N(N), .WIN(WIN)) bus ();

    soml_peak_detect #(.N(N), .Q(8), .WIN(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic fill_zero();
        for (int k = 0; k < WIN; k++) begin
            sr[k] = 0;
            si[k] = 0;
        end
    endtask

    // Small background (|r|,|i| <= 5) with one clear peak at 37.
    task automatic fill_single();
        for (int k = 0; k < WIN; k++) begin
            sr[k] = (k % 11) - 5;
            si[k] = 5 - (k % 7);
        end
        sr[37] = 100;
        si[37] = -50;
    endtask

    task automatic fill_tie();
        fill_zero();
        sr[5]  = -30; si[5]  = 30;
        sr[20] = -30; si[20] = 30;
    endtask

    // Entered and left at a negedge; returns in the peak_valid cycle.
    task automatic run_win(input string nm, input bit gap, input bit noise, input int th,
                           input int e_idx, input int e_mag, input int e_found);
        int n;
        bus.start  = 1'b1;
        bus.thresh = 17'(th);
        if (noise) begin
            bus.in_valid = 1'b1;
            bus.in_r = 16'sd1000;
            bus.in_i = 16'sd1000;
        end
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        chk({nm, ":busy_up"}, 32'(bus.busy), 1);
        chk({nm, ":clr_mag"}, 32'(bus.peak_mag), 0);
        chk({nm, ":clr_idx"}, 32'(bus.peak_idx), 0);
        for (int k = 0; k < WIN; k++) begin
            bus.in_valid = 1'b1;
            bus.in_r = 16'(sr[k]);
            bus.in_i = 16'(si[k]);
            if (noise && k == 10) bus.start = 1'b1;
            @(posedge clk); @(negedge clk);
            bus.start = 1'b0;
            if (gap && k != WIN - 1) begin
                bus.in_valid = 1'b0;
                bus.in_r = -16'sd1000;
                bus.in_i = 16'sd1000;
                @(posedge clk); @(negedge clk);
            end
        end
        bus.in_valid = noise;
        bus.in_r = 16'sd1000;
        bus.in_i = 16'sd1000;
        n = 0;
        while (!bus.peak_valid && n < 8) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        chk({nm, ":latency"}, 32'(n), 2);
        chk({nm, ":idx"}, 32'(bus.peak_idx), 32'(e_idx));
        chk({nm, ":mag"}, 32'(bus.peak_mag), 32'(e_mag));
        chk({nm, ":found"}, 32'(bus.peak_found), 32'(e_found));
    endtask

    task automatic post_chk(input string nm, input int e_idx, input int e_mag);
        @(posedge clk); @(negedge clk);
        chk({nm, ":pv_drop"}, 32'(bus.peak_valid), 0);
        chk({nm, ":busy_low"}, 32'(bus.busy), 0);
        chk({nm, ":idx_hold"}, 32'(bus.peak_idx), 32'(e_idx));
        chk({nm, ":mag_hold"}, 32'(bus.peak_mag), 32'(e_mag));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pv_seen;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_r     = '0;
        bus.in_i     = '0;
        bus.thresh   = '0;
        #12;
        chk("rst:busy",  32'(bus.busy), 0);
        chk("rst:pv",    32'(bus.peak_valid), 0);
        chk("rst:idx",   32'(bus.peak_idx), 0);
        chk("rst:mag",   32'(bus.peak_mag), 0);
        chk("rst:found", 32'(bus.peak_found), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        fill_single();
        run_win("single", 0, 0, 120, 37, 150, 1);
        post_chk("single", 37, 150);

        fill_tie();
        run_win("tie", 0, 0, 61, 5, 60, 0);
        post_chk("tie", 5, 60);

        fill_zero();
        sr[63] = -32768;
        si[63] = -32768;
        run_win("extreme", 1, 0, 65536, 63, 65536, 1);
        post_chk("extreme", 63, 65536);

        // in_valid with large samples while idle: must not be counted.
        bus.in_valid = 1'b1;
        bus.in_r = 16'sd1000;
        bus.in_i = 16'sd1000;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("ign:idle_busy", 32'(bus.busy), 0);
        fill_single();
        run_win("ign", 0, 1, 120, 37, 150, 1);
        post_chk("ign", 37, 150);

        // Reset partway through a window.
        fill_zero();
        bus.start = 1'b1;
        bus.thresh = 17'd5;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            bus.in_valid = 1'b1;
            bus.in_r = (k == 3) ? 16'sd7 : 16'sd0;
            bus.in_i = 16'sd0;
            @(posedge clk); @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("mid:mag_pre", 32'(bus.peak_mag), 7);
        rst = 1'b1;
        #1;
        chk("mid:busy", 32'(bus.busy), 0);
        chk("mid:mag",  32'(bus.peak_mag), 0);
        chk("mid:idx",  32'(bus.peak_idx), 0);
        chk("mid:pv",   32'(bus.peak_valid), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        pv_seen = 0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (bus.peak_valid) pv_seen++;
        end
        chk("mid:no_pv", 32'(pv_seen), 0);
        fill_single();
        run_win("after_rst", 0, 0, 151, 37, 150, 0);
        post_chk("after_rst", 37, 150);

        // Back-to-back: next start issued in the peak_valid cycle.
        fill_tie();
        run_win("b2b_a", 0, 0, 60, 5, 60, 1);
        chk("b2b:held", 32'(bus.peak_mag), 60);
        fill_zero();
        run_win("b2b_b", 0, 0, 0, 0, 0, 1);
        post_chk("b2b_b", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
